// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro used by the controller: HAZARD_SYSCALL_ACK_EN.
package hazard_pkg;

    // Syscall sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } hz_state_e;

    // Inter-stage register indices
    localparam int IFID  = 0;
    localparam int IDEXE = 1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives hazard sources, consumes stall/flush).
// slave : hazard controller side.
interface hazard_ctrl_if #(
    parameter int NSTAGE = 4,
    parameter int REG_W  = 5
);
    logic              MemRead_EXE;
    logic [REG_W-1:0]  rt_EXE;
    logic [REG_W-1:0]  rs_ID;
    logic [REG_W-1:0]  rt_ID;
    logic              Redirect_ID;
    logic              Syscall_IN;
    logic              Syscall_ACK;
    logic [NSTAGE-1:0] STALL;
    logic [NSTAGE-1:0] FLUSH;
    logic              Syscall_OUT;
    logic              BUSY;

    modport master (
        output MemRead_EXE, rt_EXE, rs_ID, rt_ID, Redirect_ID, Syscall_IN, Syscall_ACK,
        input  STALL, FLUSH, Syscall_OUT, BUSY
    );

    modport slave (
        input  MemRead_EXE, rt_EXE, rs_ID, rt_ID, Redirect_ID, Syscall_IN, Syscall_ACK,
        output STALL, FLUSH, Syscall_OUT, BUSY
    );
endinterface

// File: rtl/hazard_loaduse_det.sv
// Load-use interlock detector: a load in EXE whose non-zero destination
// matches either source of the instruction currently in ID.
module hazard_loaduse_det #(
    parameter int REG_W = 5
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] rt_exe,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    output logic             lu
);
    // Register $0 is never a real dependency, so it never interlocks
    always_comb begin
        lu = 1'b0;
        if (mem_read && (rt_exe != {REG_W{1'b0}}) &&
            ((rt_exe == rs_id) || (rt_exe == rt_id))) begin
            lu = 1'b1;
        end else begin
            lu = 1'b0;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch/jump redirect
// flush and a single-edge syscall drain/handshake FSM.
// Optional feature macro: HAZARD_SYSCALL_ACK_EN (WAIT held until Syscall_ACK;
// when undefined, WAIT lasts one cycle and Syscall_ACK is unused).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int REG_W  = 5
) (
    input  logic          CLOCK,
    input  logic          RESET,
    hazard_ctrl_if.slave  bus
);
    localparam int                CNT_W    = $clog2(NSTAGE);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(NSTAGE - 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    hz_state_e         state_r;
    hz_state_e         state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              lu_s;
    logic              busy_r;
    logic              sys_out_r;
    logic [NSTAGE-1:0] stall_s;
    logic [NSTAGE-1:0] flush_s;

    hazard_loaduse_det #(.REG_W(REG_W)) u_lu (
        .mem_read (bus.MemRead_EXE),
        .rt_exe   (bus.rt_EXE),
        .rs_id    (bus.rs_ID),
        .rt_id    (bus.rt_ID),
        .lu       (lu_s)
    );

`ifndef HAZARD_SYSCALL_ACK_EN
    logic unused_ack_s;
    assign unused_ack_s = bus.Syscall_ACK;
`endif

    // State, drain counter and state-decoded status flags
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            sys_out_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            sys_out_r <= (state_nxt_s == WAIT);
        end
    end

    // Next-state and drain count; a load-use cycle defers syscall acceptance
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (!lu_s && bus.Syscall_IN) begin
                    cnt_nxt_s = CNT_LOAD;
                    if (CNT_LOAD == CNT_ONE) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            DRAIN: begin
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = WAIT;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            WAIT: begin
`ifdef HAZARD_SYSCALL_ACK_EN
                if (bus.Syscall_ACK) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = WAIT;
                end
`else
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
`endif
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Stall/flush decode: same-cycle response in IDLE, bubble insertion otherwise
    always_comb begin
        stall_s = {NSTAGE{1'b0}};
        flush_s = {NSTAGE{1'b0}};
        case (state_r)
            IDLE: begin
                if (lu_s || bus.Syscall_IN) begin
                    stall_s[IFID]  = 1'b1;
                    flush_s[IDEXE] = 1'b1;
                end else if (bus.Redirect_ID) begin
                    flush_s[IFID]  = 1'b1;
                end else begin
                    stall_s = {NSTAGE{1'b0}};
                    flush_s = {NSTAGE{1'b0}};
                end
            end
            DRAIN, WAIT: begin
                stall_s[IFID]  = 1'b1;
                flush_s[IDEXE] = 1'b1;
            end
            default: begin
                stall_s = {NSTAGE{1'b0}};
                flush_s = {NSTAGE{1'b0}};
            end
        endcase
    end

    assign bus.STALL       = stall_s;
    assign bus.FLUSH       = flush_s;
    assign bus.BUSY        = busy_r;
    assign bus.Syscall_OUT = sys_out_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (NSTAGE=4). Expected values come from a
// cycle-age model of the syscall sequence; honours HAZARD_SYSCALL_ACK_EN.
module tb_hazard_ctrl;
    localparam int NSTAGE = 4;
    localparam int REG_W  = 5;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    hazard_ctrl_if #(.NSTAGE(NSTAGE), .REG_W(REG_W)) bus ();

    hazard_ctrl #(.NSTAGE(NSTAGE), .REG_W(REG_W)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    int pass_cnt  = 0;
    int total_cnt = 0;
    // -1: idle; k>=1: k cycles after the syscall was accepted
    int age = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_in(input logic mr, input int rte, input int rs, input int rt,
                          input logic red, input logic sys, input logic ack);
        bus.MemRead_EXE = mr;
        bus.rt_EXE      = REG_W'(rte);
        bus.rs_ID       = REG_W'(rs);
        bus.rt_ID       = REG_W'(rt);
        bus.Redirect_ID = red;
        bus.Syscall_IN  = sys;
        bus.Syscall_ACK = ack;
    endtask

    function automatic logic model_lu();
        return bus.MemRead_EXE && (bus.rt_EXE != 0) &&
               ((bus.rt_EXE == bus.rs_ID) || (bus.rt_EXE == bus.rt_ID));
    endfunction

    // Check this cycle's outputs at negedge, then advance the model at posedge
    task automatic do_cycle(input string tag);
        int es, ef, eb, eo;
        logic lu;
        @(negedge CLOCK);
        lu = model_lu();
        es = 0; ef = 0; eb = 0; eo = 0;
        if (age < 0) begin
            if (lu || bus.Syscall_IN) begin
                es = 1; ef = 2;
            end else if (bus.Redirect_ID) begin
                ef = 1;
            end
        end else begin
            es = 1; ef = 2; eb = 1;
            eo = (age >= NSTAGE - 1) ? 1 : 0;
        end
        chk({tag, ".stall"}, 32'(bus.STALL), 32'(es));
        chk({tag, ".flush"}, 32'(bus.FLUSH), 32'(ef));
        chk({tag, ".busy"},  32'(bus.BUSY), 32'(eb));
        chk({tag, ".sysout"}, 32'(bus.Syscall_OUT), 32'(eo));
        @(posedge CLOCK);
        if (!RESET) begin
            age = -1;
        end else if (age < 0) begin
            if (!lu && bus.Syscall_IN) age = 1;
        end else if (age >= NSTAGE - 1) begin
`ifdef HAZARD_SYSCALL_ACK_EN
            if (bus.Syscall_ACK) age = -1;
`else
            age = -1;
`endif
        end else begin
            age++;
        end
        #1;
    endtask

    initial begin
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Reset state
        do_cycle("reset0");
        do_cycle("reset1");
        RESET = 1'b1;
        do_cycle("idle");

        // Load-use hit, then rt_EXE=0 (never interlocks)
        set_in(1'b1, 8, 8, 3, 1'b0, 1'b0, 1'b0);  do_cycle("lu_rs");
        set_in(1'b1, 9, 2, 9, 1'b0, 1'b0, 1'b0);  do_cycle("lu_rt");
        set_in(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);  do_cycle("lu_r0");
        set_in(1'b0, 8, 8, 8, 1'b0, 1'b0, 1'b0);  do_cycle("no_load");

        // Redirect alone, and combined with lu
        set_in(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);  do_cycle("redir");
        set_in(1'b1, 7, 7, 1, 1'b1, 1'b0, 1'b0);  do_cycle("redir_lu");

        // Syscall pulse at cycle 0, ACK at cycle 6, idle at cycle 7
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);  do_cycle("sc_c0");
        set_in(1'b1, 4, 4, 4, 1'b1, 1'b1, 1'b0);  do_cycle("sc_c1");
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 5; c++) do_cycle($sformatf("sc_c%0d", c));
        bus.Syscall_ACK = 1'b1;                   do_cycle("sc_c6");
        bus.Syscall_ACK = 1'b0;                   do_cycle("sc_c7");
        do_cycle("sc_c8");

        // Syscall together with lu: accept deferred one cycle
        set_in(1'b1, 5, 5, 0, 1'b0, 1'b1, 1'b0);  do_cycle("sclu_c0");
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);  do_cycle("sclu_c1");
        bus.Syscall_IN = 1'b0;
        for (int c = 2; c <= 5; c++) do_cycle($sformatf("sclu_c%0d", c));
        bus.Syscall_ACK = 1'b1;                   do_cycle("sclu_ack");
        bus.Syscall_ACK = 1'b0;                   do_cycle("sclu_idle");

        // Reset asserted in DRAIN cycle 2: immediate release, later ACK ignored
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);  do_cycle("rst_c0");
        bus.Syscall_IN = 1'b0;                    do_cycle("rst_c1");
        RESET = 1'b0;
        age   = -1;
        #1;
        chk("rst_async.busy",   32'(bus.BUSY), 32'd0);
        chk("rst_async.sysout", 32'(bus.Syscall_OUT), 32'd0);
        do_cycle("rst_low");
        RESET = 1'b1;
        bus.Syscall_ACK = 1'b1;                   do_cycle("rst_ack");
        bus.Syscall_ACK = 1'b0;                   do_cycle("rst_after");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 1) == 1), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0));
            do_cycle("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
